// File: rtl/pipe_rc_adder.sv
// Pipelined ripple-carry adder/subtractor.
// The operands are split into STAGES equal segments of WIDTH/STAGES bits.
// Stage k ripples segment k and registers its carry for stage k+1.
// Operand bits that have not been added yet travel alongside the carry.
// Sum segments that are already done travel alongside as well.
// As a result, every segment of one transaction leaves the last stage together.
//
// Handshake: a transfer happens on a rising edge where valid && ready are both 1.
// The producer holds valid and data stable until that edge; ready may be
// combinational. The whole pipeline advances when the output register is
// empty or is being drained (adv = !out_valid || out_ready). When adv is low,
// every register holds. in_ready equals adv.
module pipe_rc_adder #(
    parameter int WIDTH  = 24,
    parameter int STAGES = 3
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf
);

    localparam int SEG  = WIDTH / STAGES;
    localparam int LAST = STAGES - 1;

    // Per-stage registers. b_q already holds b' (b inverted for subtract).
    logic [WIDTH-1:0] a_q [STAGES];
    logic [WIDTH-1:0] b_q [STAGES];
    logic [WIDTH-1:0] s_q [STAGES];
    logic             c_q [STAGES];
    logic             v_q [STAGES];
    logic             ovf_q;

    // Stage inputs: stage 0 reads the ports, and each later stage reads the previous register.
    logic [WIDTH-1:0] st_a [STAGES];
    logic [WIDTH-1:0] st_b [STAGES];
    logic [WIDTH-1:0] st_s [STAGES];
    logic             st_c [STAGES];
    logic             st_v [STAGES];

    // Stage results before registering
    logic [WIDTH-1:0] n_s [STAGES];
    logic             n_c [STAGES];
    logic             n_ovf;
    logic [SEG:0]     seg_r;
    logic             adv;

    assign out_valid = v_q[LAST];
    assign sum       = s_q[LAST];
    assign cout      = c_q[LAST];
    assign ovf       = ovf_q;
    assign adv       = !out_valid || out_ready;
    assign in_ready  = adv;

    // Select the inputs for each stage. sub forces carry-in 1 and inverts b on entry.
    always_comb begin
        st_a[0] = a;
        st_b[0] = sub ? ~b : b;
        st_c[0] = sub | cin;
        st_s[0] = '0;
        st_v[0] = in_valid;
        for (int k = 1; k < STAGES; k++) begin
            st_a[k] = a_q[k-1];
            st_b[k] = b_q[k-1];
            st_c[k] = c_q[k-1];
            st_s[k] = s_q[k-1];
            st_v[k] = v_q[k-1];
        end
    end

    // Ripple one segment per stage. The final stage also derives the signed overflow.
    always_comb begin
        seg_r = '0;
        n_ovf = 1'b0;
        for (int k = 0; k < STAGES; k++) begin
            seg_r = {1'b0, st_a[k][k*SEG +: SEG]}
                  + {1'b0, st_b[k][k*SEG +: SEG]}
                  + {{SEG{1'b0}}, st_c[k]};
            n_s[k] = st_s[k];
            n_s[k][k*SEG +: SEG] = seg_r[SEG-1:0];
            n_c[k] = seg_r[SEG];
        end
        // carry into MSB = s ^ a ^ b' at that bit; overflow = that XOR carry out
        n_ovf = (n_s[LAST][WIDTH-1] ^ st_a[LAST][WIDTH-1] ^ st_b[LAST][WIDTH-1])
              ^ n_c[LAST];
    end

    // Pipeline registers: cleared by reset, and advance together only when adv is 1.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < STAGES; k++) begin
                a_q[k] <= '0;
                b_q[k] <= '0;
                s_q[k] <= '0;
                c_q[k] <= 1'b0;
                v_q[k] <= 1'b0;
            end
            ovf_q <= 1'b0;
        end else if (adv) begin
            for (int k = 0; k < STAGES; k++) begin
                a_q[k] <= st_a[k];
                b_q[k] <= st_b[k];
                s_q[k] <= n_s[k];
                c_q[k] <= n_c[k];
                v_q[k] <= st_v[k];
            end
            ovf_q <= n_ovf;
        end
    end

endmodule

// File: tb/tb_pipe_rc_adder.sv
// Bench for pipe_rc_adder. The main instance is 24-bit with 3 stages.
// Two further instances share the same stimulus: a 24-bit instance with 1 stage,
// and a 32-bit instance with 4 stages. Those two always drain their output
// (out_ready tied high) and are checked against a behavioural reference.
module tb_pipe_rc_adder;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n;
    logic        in_valid;
    logic [31:0] a, b;
    logic        cin, sub;
    logic        out_ready;

    logic        in_ready, out_valid, cout, ovf;
    logic [23:0] sum;
    logic        in_ready1, out_valid1, cout1, ovf1;
    logic [23:0] sum1;
    logic        in_ready4, out_valid4, cout4, ovf4;
    logic [31:0] sum4;

    pipe_rc_adder #(.WIDTH(24), .STAGES(3)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .a(a[23:0]), .b(b[23:0]), .cin(cin), .sub(sub),
        .out_valid(out_valid), .out_ready(out_ready),
        .sum(sum), .cout(cout), .ovf(ovf));

    pipe_rc_adder #(.WIDTH(24), .STAGES(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready1),
        .a(a[23:0]), .b(b[23:0]), .cin(cin), .sub(sub),
        .out_valid(out_valid1), .out_ready(1'b1),
        .sum(sum1), .cout(cout1), .ovf(ovf1));

    pipe_rc_adder #(.WIDTH(32), .STAGES(4)) dut4 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready4),
        .a(a), .b(b), .cin(cin), .sub(sub),
        .out_valid(out_valid4), .out_ready(1'b1),
        .sum(sum4), .cout(cout4), .ovf(ovf4));

    // ---------------- scoreboard state ----------------
    logic [23:0] e_sum;
    logic        e_cout, e_ovf;
    logic [25:0] exp_q[$];
    int          acc_q[$];
    logic [33:0] exp1_q[$];
    logic [33:0] exp4_q[$];
    int          cyc = 0;
    bit          lat_chk = 1'b0;
    int          n_cmp = 0;
    int          n_bad = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Behavioural reference: {ovf, cout, sum} for width w
    function automatic logic [33:0] ref_add(input logic [31:0] x, input logic [31:0] y,
                                            input logic ci, input logic sb, input int w);
        logic [32:0] m, r;
        logic [31:0] yy;
        logic        c0, cm, co;
        m  = (33'd1 << w) - 33'd1;
        yy = sb ? ~y : y;
        c0 = sb ? 1'b1 : ci;
        r  = ({1'b0, x} & m) + ({1'b0, yy} & m) + {32'd0, c0};
        co = r[w];
        cm = r[w-1] ^ x[w-1] ^ yy[w-1];
        return {cm ^ co, co, r[31:0] & m[31:0]};
    endfunction

    // Push expected results on every accepted input (sampled at negedge)
    always @(negedge clk) begin
        if (rst_n) begin
            if (in_valid && in_ready) begin
                exp_q.push_back({e_ovf, e_cout, e_sum});
                acc_q.push_back(cyc);
            end
            if (in_valid && in_ready1) exp1_q.push_back(ref_add(a, b, cin, sub, 24));
            if (in_valid && in_ready4) exp4_q.push_back(ref_add(a, b, cin, sub, 32));
        end
    end

    // Monitor: pop and compare whenever an output handshake completes
    always @(negedge clk) begin
        logic [25:0] ex;
        logic [33:0] ex1;
        int          t;
        if (rst_n) begin
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) chk("main_spurious_valid", {63'd0, out_valid}, 64'd0);
                else begin
                    ex = exp_q.pop_front();
                    t  = acc_q.pop_front();
                    chk("main_result", {38'd0, ovf, cout, sum}, {38'd0, ex});
                    if (lat_chk) chk("main_latency", 64'(cyc - t), 64'd3);
                end
            end
            if (out_valid1) begin
                if (exp1_q.size() == 0) chk("s1_spurious_valid", {63'd0, out_valid1}, 64'd0);
                else begin
                    ex1 = exp1_q.pop_front();
                    chk("s1_result", {30'd0, ovf1, cout1, 8'd0, sum1}, {30'd0, ex1});
                end
            end
            if (out_valid4) begin
                if (exp4_q.size() == 0) chk("w32_spurious_valid", {63'd0, out_valid4}, 64'd0);
                else begin
                    ex1 = exp4_q.pop_front();
                    chk("w32_result", {30'd0, ovf4, cout4, sum4}, {30'd0, ex1});
                end
            end
        end
    end

    // ---------------- driver tasks (enter and leave at posedge + 1) ----------------
    task automatic send(input logic [31:0] x, input logic [31:0] y, input logic ci,
                        input logic sb, input logic [23:0] es, input logic ec, input logic eo);
        int n;
        a = x; b = y; cin = ci; sub = sb;
        e_sum = es; e_cout = ec; e_ovf = eo;
        in_valid = 1'b1;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!in_ready && n < 50);
        if (!in_ready) chk("send_timeout", {63'd0, in_ready}, 64'd1);
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        in_valid = 1'b0;
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    // ---------------- directed sequence ----------------
    initial begin
        int n;
        rst_n = 1'b1; in_valid = 1'b0; a = '0; b = '0; cin = 1'b0; sub = 1'b0;
        out_ready = 1'b1; e_sum = '0; e_cout = 1'b0; e_ovf = 1'b0;
        #2 rst_n = 1'b0;
        @(negedge clk);
        chk("reset_out_valid", {63'd0, out_valid}, 64'd0);
        chk("reset_sum", {40'd0, sum}, 64'd0);
        chk("reset_cout_ovf", {62'd0, cout, ovf}, 64'd0);
        chk("reset_in_ready", {63'd0, in_ready}, 64'd1);
        @(posedge clk); #1 rst_n = 1'b1;
        idle(1);

        // back-to-back adds, latency 3
        lat_chk = 1'b1;
        send(32'd98, 32'd48, 1'b0, 1'b0, 24'd146, 1'b0, 1'b0);
        send(32'd538, 32'd34849, 1'b1, 1'b0, 24'd35388, 1'b0, 1'b0);
        send(32'd2746128, 32'd2141202, 1'b1, 1'b0, 24'd4887331, 1'b0, 1'b0);
        // wrap and signed overflow (upper bits exercise the 32-bit instance)
        send(32'hFFFFFFFF, 32'd1, 1'b0, 1'b0, 24'h000000, 1'b1, 1'b0);
        send(32'h007FFFFF, 32'd1, 1'b0, 1'b0, 24'h800000, 1'b0, 1'b1);
        send(32'h7FFFFFFF, 32'd1, 1'b0, 1'b0, 24'h000000, 1'b1, 1'b0);
        // subtract, cin ignored
        send(32'd100, 32'd58, 1'b1, 1'b1, 24'd42, 1'b1, 1'b0);
        send(32'd5, 32'd7, 1'b1, 1'b1, 24'd16777214, 1'b0, 1'b0);
        idle(1);
        // bubble pattern 1,0,1
        send(32'd1000, 32'd2000, 1'b0, 1'b0, 24'd3000, 1'b0, 1'b0);
        idle(1);
        send(32'd123456, 32'd654321, 1'b0, 1'b0, 24'd777777, 1'b0, 1'b0);
        idle(6);

        // backpressure
        lat_chk = 1'b0;
        send(32'd10, 32'd20, 1'b0, 1'b0, 24'd30, 1'b0, 1'b0);
        out_ready = 1'b0;
        send(32'd300, 32'd400, 1'b1, 1'b0, 24'd701, 1'b0, 1'b0);
        send(32'h123456, 32'h111111, 1'b0, 1'b0, 24'h234567, 1'b0, 1'b0);
        in_valid = 1'b0;
        n = 0;
        while (!out_valid && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
        chk("bp_first_valid", {63'd0, out_valid}, 64'd1);
        repeat (4) begin
            @(negedge clk);
            chk("bp_in_ready_low", {63'd0, in_ready}, 64'd0);
            chk("bp_hold", {38'd0, out_valid, cout, ovf, sum}, {38'd0, 1'b1, 1'b0, 1'b0, 24'd30});
        end
        @(posedge clk); #1 out_ready = 1'b1;
        idle(6);

        // asynchronous reset mid-flight
        lat_chk = 1'b1;
        send(32'd11, 32'd22, 1'b0, 1'b0, 24'd33, 1'b0, 1'b0);
        send(32'd44, 32'd55, 1'b0, 1'b0, 24'd99, 1'b0, 1'b0);
        idle(1);
        #2 rst_n = 1'b0;
        exp_q.delete(); acc_q.delete(); exp1_q.delete(); exp4_q.delete();
        #1;
        chk("rst_out_valid", {61'd0, out_valid, out_valid1, out_valid4}, 64'd0);
        chk("rst_sum", {40'd0, sum}, 64'd0);
        chk("rst_cout_ovf", {62'd0, cout, ovf}, 64'd0);
        chk("rst_in_ready", {63'd0, in_ready}, 64'd1);
        repeat (2) @(posedge clk);
        #3 rst_n = 1'b1;
        repeat (6) begin
            @(negedge clk);
            chk("rst_no_stale", {62'd0, out_valid, out_valid4}, 64'd0);
        end
        @(posedge clk); #1;
        send(32'd98, 32'd48, 1'b0, 1'b0, 24'd146, 1'b0, 1'b0);
        idle(8);

        chk("main_queue_empty", 64'(exp_q.size()), 64'd0);
        chk("s1_queue_empty", 64'(exp1_q.size()), 64'd0);
        chk("w32_queue_empty", 64'(exp4_q.size()), 64'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
